mvm_ctrl: RTL and testbench
===========================

Name: mvm_ctrl

Overview:
- Sequencing controller plus row-parallel MAC array for the matrix-vector multiply stage of the accelerator.
- Accepts one flattened matrix and vector per job over a valid/ready handshake and latches them.
- Steps the shared dimension one column per cycle, accumulating matrix[r][k]*vector[k] into every row accumulator in parallel.
- Presents the finished result vector on a valid/ready output handshake to the activation/next-layer stage.

Parameters:
- MATRIX_ROWS, 6: rows in matrix; result vector length.
- SHARED_DIM, 3: matrix columns; vector length.
- WIDTH, 8: signed two's-complement operand width.
- ACC_WIDTH, 2*WIDTH+$clog2(SHARED_DIM) (18): signed accumulator/result width; legal range >= 2*WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous abort; drops the current job.
- in_valid  in  1  job operands valid.
- in_ready  out  1  controller can accept a job.
- matrix  in  MATRIX_ROWS*SHARED_DIM*WIDTH  element (r,k) at [(r*SHARED_DIM+k)*WIDTH +: WIDTH].
- vector  in  SHARED_DIM*WIDTH  element k at [k*WIDTH +: WIDTH].
- out_valid  out  1  result_vector valid.
- out_ready  in  1  consumer accepts result.
- result_vector  out  MATRIX_ROWS*ACC_WIDTH  row r at [r*ACC_WIDTH +: ACC_WIDTH], signed.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, k=0, accumulators=0, latched operands=0.
  - Outputs after reset: in_ready=1, out_valid=0, busy=0, result_vector=0.
- States IDLE, CALC, DONE; encoding 2 bits; outputs decoded from registered state only.
- IDLE: in_ready=1.
  - On edge with in_valid=1: latch matrix and vector, clear all accumulators, k=0, go CALC.
- CALC: in_ready=0.
  - Each edge: acc[r] += sext(m[r][k]) * sext(v[k]) for all r in parallel, using latched operands.
  - If k==SHARED_DIM-1: go DONE, k=0. Else k=k+1.
  - CALC lasts exactly SHARED_DIM cycles.
- DONE: out_valid=1; result_vector = accumulators, held stable while out_ready=0.
  - On edge with out_ready=1: go IDLE.
  - Accumulators retain their value until the next accept.
- Latency and throughput:
  - out_valid rises SHARED_DIM clock edges after the accept edge.
  - Back-to-back period is SHARED_DIM+2 cycles. There is no accept/output overlap: in_ready is 0 in DONE.
- Handshake rules:
  - in_valid with in_ready=0 is ignored; no operand capture.
  - Input operands are don't-care except on the accept edge.
  - out_valid, once high, stays high until out_ready or clear/reset.
- clear: at next edge, from any state, go IDLE and zero k and accumulators. It has priority over in_valid, so an accept is suppressed on that edge. out_valid is low the following cycle.
- Arithmetic: products are 2*WIDTH signed; accumulation is signed modulo 2^ACC_WIDTH. At the default ACC_WIDTH overflow is impossible; a narrower ACC_WIDTH wraps silently.
- SHARED_DIM=1: CALC lasts one cycle; the k counter is min 1 bit wide.
- Changing inputs mid-job has no effect, because operands are latched.

Decomposition:
- Package mvm_pkg:
  - State encodings IDLE=2'b00, CALC=2'b01, DONE=2'b10.
  - acc_width(WIDTH, SHARED_DIM) function.
  - Index helper for flattened element offsets.
- Sub-module mvm_acc_array (MATRIX_ROWS, WIDTH, ACC_WIDTH):
  - Column input of MATRIX_ROWS*WIDTH, scalar input of WIDTH.
  - clr and en inputs; acc outputs.
  - The controller owns the FSM, k counter, operand latches and handshakes.

Test Plan:
- Reset/idle:
  - After reset release: in_ready=1, out_valid=0, busy=0, result_vector=0.
  - out_ready toggling in IDLE causes no state change.
- Basic job:
  - Stimulus: all elements of row r = r+1, vector=[1,2,3].
  - Required: out_valid exactly 3 edges after accept; rows = 6,12,18,24,30,36.
- Signed extremes:
  - All m=-128, v=-128 → every row 49152.
  - All m=127, v=-128 → every row -48768; no wrap at ACC_WIDTH=18.
- Backpressure:
  - Hold out_ready=0 for 10 cycles with in_valid=1 and changing operands.
  - Required: out_valid held, result_vector unchanged, in_ready=0, no new accept.
  - Raise out_ready: IDLE next edge, accept on the following edge.
- Throughput:
  - in_valid=1 and out_ready=1 continuously with 4 distinct jobs.
  - Required: results in order, one per 5 cycles, each matching a reference model.
- Abort:
  - clear pulsed at k=1 in CALC → IDLE next cycle, no out_valid.
  - Async reset asserted mid-DONE → out_valid=0 immediately.
  - Next job after either case produces the correct fresh result with no stale accumulation.

Source files
------------

// File: rtl/mvm_pkg.sv
// Shared types and helpers for the matrix-vector multiply controller.
package mvm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;

    // Accumulator width that cannot overflow for a full dot product.
    function automatic int acc_width(input int width, input int shared_dim);
        return 2 * width + $clog2(shared_dim);
    endfunction

    // Bit offset of element (row, col) in a row-major flattened array.
    function automatic int unsigned elem_offset(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned cols,
                                                input int unsigned width);
        return (row * cols + col) * width;
    endfunction

endpackage

// File: rtl/mvm_acc_array.sv
// Row-parallel signed multiply-accumulate array: every row adds
// col[r] * scalar into its own accumulator when enabled.
module mvm_acc_array #(
    parameter int MATRIX_ROWS = 6,
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = 18
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clr,
    input  logic                             en,
    input  logic [MATRIX_ROWS*WIDTH-1:0]     col,
    input  logic [WIDTH-1:0]                 scalar,
    output logic [MATRIX_ROWS*ACC_WIDTH-1:0] acc
);

    logic signed [2*WIDTH-1:0]   prod  [MATRIX_ROWS];
    logic signed [ACC_WIDTH-1:0] acc_q [MATRIX_ROWS];
    logic signed [ACC_WIDTH-1:0] acc_d [MATRIX_ROWS];

    // Full-precision signed products of each column element with the scalar.
    always_comb begin
        for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
            prod[r] = (2*WIDTH)'($signed(col[r*WIDTH +: WIDTH]))
                    * (2*WIDTH)'($signed(scalar));
        end
    end

    // Next accumulator values: clear wins over accumulate; wraps modulo 2^ACC_WIDTH.
    always_comb begin
        for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
            acc_d[r] = acc_q[r];
            if (clr) begin
                acc_d[r] = '0;
            end else if (en) begin
                acc_d[r] = acc_q[r] + ACC_WIDTH'(prod[r]);
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
                acc_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
                acc_q[r] <= acc_d[r];
            end
        end
    end

    // Flatten accumulators onto the output bus.
    always_comb begin
        acc = '0;
        for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
            acc[r*ACC_WIDTH +: ACC_WIDTH] = acc_q[r];
        end
    end

endmodule

// File: rtl/mvm_ctrl.sv
// Matrix-vector multiply controller: accepts a job, steps the shared
// dimension one column per cycle through the MAC array, then holds the
// result until the consumer takes it.
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter int MATRIX_ROWS = 6,
    parameter int SHARED_DIM  = 3,
    parameter int WIDTH       = 8,
    parameter int ACC_WIDTH   = acc_width(WIDTH, SHARED_DIM)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    clear,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
    input  logic [SHARED_DIM*WIDTH-1:0]             vector,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [MATRIX_ROWS*ACC_WIDTH-1:0]        result_vector,
    output logic                                    busy
);

    localparam int KW = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SHARED_DIM - 1);

    state_e                                  state_q, state_d;
    logic [KW-1:0]                           k_q, k_d;
    logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] mat_q, mat_d;
    logic [SHARED_DIM*WIDTH-1:0]             vec_q, vec_d;
    logic [MATRIX_ROWS*WIDTH-1:0]            col;
    logic [WIDTH-1:0]                        scalar;
    logic                                    accept;
    logic                                    acc_clr;
    logic                                    acc_en;

    // Job acceptance and MAC array control; clear suppresses an accept.
    always_comb begin
        accept  = (state_q == IDLE) && in_valid && !clear;
        acc_clr = clear || accept;
        acc_en  = (state_q == CALC) && !clear;
    end

    // State, column counter and operand latch registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            mat_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            mat_q   <= mat_d;
            vec_q   <= vec_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (in_valid)      state_d = CALC;
                CALC:    if (k_q == K_LAST) state_d = DONE;
                DONE:    if (out_ready)     state_d = IDLE;
                default:                    state_d = IDLE;
            endcase
        end
    end

    // Column counter and operand capture.
    always_comb begin
        k_d   = k_q;
        mat_d = mat_q;
        vec_d = vec_q;
        if (clear) begin
            k_d = '0;
        end else if (accept) begin
            k_d   = '0;
            mat_d = matrix;
            vec_d = vector;
        end else if (state_q == CALC) begin
            k_d = (k_q == K_LAST) ? '0 : k_q + KW'(1);
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
    end

    // Select column k of the latched matrix and element k of the latched vector.
    always_comb begin
        col    = '0;
        scalar = vec_q[elem_offset(0, 32'(k_q), SHARED_DIM, WIDTH) +: WIDTH];
        for (int unsigned r = 0; r < MATRIX_ROWS; r++) begin
            col[r*WIDTH +: WIDTH] =
                mat_q[elem_offset(r, 32'(k_q), SHARED_DIM, WIDTH) +: WIDTH];
        end
    end

    mvm_acc_array #(
        .MATRIX_ROWS (MATRIX_ROWS),
        .WIDTH       (WIDTH),
        .ACC_WIDTH   (ACC_WIDTH)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .clr    (acc_clr),
        .en     (acc_en),
        .col    (col),
        .scalar (scalar),
        .acc    (result_vector)
    );

endmodule

// File: tb/tb_mvm_ctrl.sv
// Self-checking bench for mvm_ctrl with a cycle-level behavioural model.
module tb_mvm_ctrl;

    localparam int R  = 6;
    localparam int SD = 3;
    localparam int W  = 8;
    localparam int AW = 18;
    localparam int MW = R * SD * W;
    localparam int VW = SD * W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [MW-1:0] matrix = '0;
    logic [VW-1:0] vector = '0;
    logic          in_ready;
    logic          out_valid;
    logic          busy;
    logic [R*AW-1:0] result_vector;

    always #5 clk = ~clk;

    mvm_ctrl #(
        .MATRIX_ROWS (R),
        .SHARED_DIM  (SD),
        .WIDTH       (W),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .matrix        (matrix),
        .vector        (vector),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result_vector (result_vector),
        .busy          (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic longint row(input int r);
        return longint'($signed(result_vector[r*AW +: AW]));
    endfunction

    // Behavioural model: a job is either absent or has n columns summed so far.
    bit     m_busy = 1'b0;
    int     m_n    = 0;
    longint m_m [R][SD];
    longint m_v [SD];

    function automatic longint exp_row(input int r);
        longint s = 0;
        for (int k = 0; k < m_n; k++) s += m_m[r][k] * m_v[k];
        s = s & ((longint'(1) << AW) - 1);
        if (s >= (longint'(1) << (AW - 1))) s -= (longint'(1) << AW);
        return s;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_n    = 0;
            for (int r = 0; r < R; r++)
                for (int k = 0; k < SD; k++) m_m[r][k] = 0;
            for (int k = 0; k < SD; k++) m_v[k] = 0;
        end else if (clear) begin
            m_busy = 1'b0;
            m_n    = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                for (int r = 0; r < R; r++)
                    for (int k = 0; k < SD; k++)
                        m_m[r][k] = longint'($signed(matrix[(r*SD+k)*W +: W]));
                for (int k = 0; k < SD; k++) m_v[k] = longint'($signed(vector[k*W +: W]));
                m_busy = 1'b1;
                m_n    = 0;
            end
        end else if (m_n < SD) begin
            m_n++;
        end else if (out_ready) begin
            m_busy = 1'b0;
        end
    end

    // Every cycle out of reset, all outputs must match the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", longint'(in_ready), longint'(!m_busy));
            chk("out_valid", longint'(out_valid), longint'(m_busy && (m_n == SD)));
            chk("busy", longint'(busy), longint'(m_busy));
            for (int r = 0; r < R; r++) chk($sformatf("row%0d", r), row(r), exp_row(r));
        end
    end

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < R * SD; i++) m[i*W +: W] = W'($urandom);
        return m;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < SD; i++) v[i*W +: W] = W'($urandom);
        return v;
    endfunction

    function automatic logic [MW-1:0] fill_mat(input int mode, input int val);
        logic [MW-1:0] m;
        for (int r = 0; r < R; r++)
            for (int k = 0; k < SD; k++)
                m[(r*SD+k)*W +: W] = (mode == 0) ? W'(r + 1) : W'(val);
        return m;
    endfunction

    function automatic logic [VW-1:0] fill_vec(input int mode, input int val);
        logic [VW-1:0] v;
        for (int k = 0; k < SD; k++) v[k*W +: W] = (mode == 0) ? W'(k + 1) : W'(val);
        return v;
    endfunction

    // Present a job for one edge (assumes idle), then scramble the operands.
    task automatic accept_job(input logic [MW-1:0] m, input logic [VW-1:0] v);
        @(negedge clk);
        matrix   = m;
        vector   = v;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        matrix   = rand_mat();
        vector   = rand_vec();
    endtask

    // Wait (bounded) for out_valid; latency counted in edges after the accept edge.
    task automatic wait_done(input string name);
        int c = 0;
        while (!out_valid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk(name, c, SD);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic chk_rows(input string name, input longint base, input bit per_row);
        for (int r = 0; r < R; r++)
            chk($sformatf("%s_row%0d", name, r), row(r), per_row ? base * (r + 1) : base);
    endtask

    initial begin
        logic [MW-1:0] mx;
        logic [VW-1:0] vx;
        logic [MW-1:0] jm [4];
        logic [VW-1:0] jv [4];
        longint snap [R];
        int rises [$];
        int j, cyc;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk_rows("rst", 0, 1'b0);

        // out_ready activity while idle must not start anything
        repeat (4) begin
            @(negedge clk);
            out_ready = ~out_ready;
        end
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_toggle_busy", longint'(busy), 0);

        // basic job: row r = r+1 everywhere, vector [1,2,3] -> 6*(r+1)
        accept_job(fill_mat(0, 0), fill_vec(0, 0));
        wait_done("basic_latency");
        chk_rows("basic", 6, 1'b1);
        release_out();

        // signed extremes
        accept_job(fill_mat(1, -128), fill_vec(1, -128));
        wait_done("neg_neg_latency");
        chk_rows("neg_neg", 49152, 1'b0);
        release_out();
        accept_job(fill_mat(1, 127), fill_vec(1, -128));
        wait_done("pos_neg_latency");
        chk_rows("pos_neg", -48768, 1'b0);

        // backpressure: held in DONE with in_valid and changing operands
        for (int r = 0; r < R; r++) snap[r] = row(r);
        repeat (10) begin
            @(negedge clk);
            in_valid = 1'b1;
            matrix   = rand_mat();
            vector   = rand_vec();
            chk("bp_in_ready", longint'(in_ready), 0);
            chk("bp_out_valid", longint'(out_valid), 1);
            for (int r = 0; r < R; r++) chk("bp_hold", row(r), snap[r]);
        end
        mx = rand_mat();
        vx = rand_vec();
        @(negedge clk);
        out_ready = 1'b1;
        matrix    = mx;
        vector    = vx;
        @(negedge clk);
        chk("bp_release_in_ready", longint'(in_ready), 1);
        chk("bp_release_out_valid", longint'(out_valid), 0);
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_accept_busy", longint'(busy), 1);
        in_valid = 1'b0;
        matrix   = rand_mat();
        wait_done("bp_job_latency");
        release_out();

        // throughput: four jobs back to back with out_ready held high
        for (int i = 0; i < 4; i++) begin
            jm[i] = rand_mat();
            jv[i] = rand_vec();
        end
        out_ready = 1'b1;
        j = 0;
        for (cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            if (out_valid) rises.push_back(cyc);
            if (!m_busy && j < 4) begin
                matrix   = jm[j];
                vector   = jv[j];
                in_valid = 1'b1;
                j++;
            end else if (!m_busy) begin
                in_valid = 1'b0;
            end else begin
                matrix = rand_mat();
                vector = rand_vec();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("tp_result_count", rises.size(), 4);
        for (int i = 1; i < rises.size(); i++)
            chk("tp_period", rises[i] - rises[i-1], SD + 2);

        // clear at k=1 aborts the job
        accept_job(rand_mat(), rand_vec());
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_in_ready", longint'(in_ready), 1);
        chk("clr_out_valid", longint'(out_valid), 0);
        chk_rows("clr", 0, 1'b0);
        repeat (6) begin
            @(negedge clk);
            chk("clr_no_out_valid", longint'(out_valid), 0);
        end
        accept_job(fill_mat(0, 0), fill_vec(0, 0));
        wait_done("after_clr_latency");
        chk_rows("after_clr", 6, 1'b1);

        // asynchronous reset while holding a result
        #1 reset = 1'b1;
        #1;
        chk("arst_out_valid", longint'(out_valid), 0);
        chk("arst_busy", longint'(busy), 0);
        chk("arst_in_ready", longint'(in_ready), 1);
        chk_rows("arst", 0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        accept_job(fill_mat(1, -128), fill_vec(1, -128));
        wait_done("after_arst_latency");
        chk_rows("after_arst", 49152, 1'b0);
        release_out();

        // random traffic with stalls and occasional clears
        repeat (400) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 15) == 0);
            matrix    = rand_mat();
            vector    = rand_vec();
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
